// File: rtl/mcd212_pkg.sv
// Shared types for the MCD212 display-fetch path: ICA opcodes, FSM state,
// decoded instruction view.
package mcd212_pkg;

  localparam logic [3:0] OP_STOP     = 4'h0;
  localparam logic [3:0] OP_NOP      = 4'h1;
  localparam logic [3:0] OP_DCP      = 4'h2;
  localparam logic [3:0] OP_DCP_STOP = 4'h3;
  localparam logic [3:0] OP_JUMP     = 4'h4;
  localparam logic [3:0] OP_VSR_STOP = 4'h5;
  localparam logic [3:0] OP_INT      = 4'h6;
  localparam logic [3:0] OP_DPARM    = 4'h7;

  typedef enum logic [1:0] {
    ICA_IDLE, ICA_FETCH_HI, ICA_FETCH_LO, ICA_EXEC
  } ica_state_e;

  // adr overlaps op[2:0]; data[21:0] doubles as the jump / VSR target
  typedef struct packed {
    logic [3:0]  op;
    logic [6:0]  adr;
    logic [23:0] data;
  } ica_instr_t;

  function automatic ica_instr_t ica_decode(input logic [31:0] w);
    ica_instr_t d;
    d.op   = w[31:28];
    d.adr  = w[30:24];
    d.data = w[23:0];
    return d;
  endfunction

endpackage

// File: rtl/clut_rle.sv
// RL7 decoder: single-pixel codes and colour+length runs, clipped at the
// end of the current line. Output holds until the consumer strobes it.
module clut_rle #(
  parameter int LINE_WIDTH = 384
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reload_vsr,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic [7:0] pixel,
  output logic       pixel_write,
  input  logic       pixel_strobe
);

  localparam int XW = ($clog2(LINE_WIDTH + 1) > 8) ? $clog2(LINE_WIDTH + 1) : 8;
  localparam logic [XW-1:0] LW   = XW'(LINE_WIDTH);
  localparam logic [XW-1:0] LAST = XW'(LINE_WIDTH - 1);

  logic [XW-1:0] r_x, r_run;
  logic          r_need_len, r_pw;
  logic [6:0]    r_color;
  logic [7:0]    r_pix;
  logic [XW-1:0] w_remain, w_n, w_len, w_x_next;
  logic          w_free, w_in_run, w_emit;
  logic [6:0]    w_emit_color;

  assign w_free       = !r_pw || pixel_strobe;
  assign w_in_run     = (r_run != '0);
  assign w_remain     = LW - r_x;
  assign w_n          = XW'(byte_data);
  assign w_len        = (w_n == '0 || w_n > w_remain) ? w_remain : w_n;
  assign w_x_next     = (r_x == LAST) ? '0 : r_x + 1'b1;
  // a colour/literal code needs a free output only when it emits a pixel
  assign byte_strobe  = byte_valid && !reload_vsr && !w_in_run &&
                        (r_need_len || byte_data[7] || w_free);
  assign w_emit       = !reload_vsr && ((w_in_run && w_free) ||
                        (byte_strobe && !r_need_len && !byte_data[7]));
  assign w_emit_color = w_in_run ? r_color : byte_data[6:0];
  assign pixel        = r_pix;
  assign pixel_write  = r_pw;

  // decoder state: line position, run counter, pending colour
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_run      <= '0;
      r_need_len <= 1'b0;
      r_color    <= '0;
    end else if (reload_vsr) begin
      r_x        <= '0;
      r_run      <= '0;
      r_need_len <= 1'b0;
    end else begin
      if (w_emit) begin
        r_x <= w_x_next;
        if (w_in_run) r_run <= r_run - 1'b1;
      end
      if (byte_strobe) begin
        if (r_need_len) begin
          r_run      <= w_len;
          r_need_len <= 1'b0;
        end else if (byte_data[7]) begin
          r_color    <= byte_data[6:0];
          r_need_len <= 1'b1;
        end
      end
    end
  end

  // output register: load on emit, clear when consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pw  <= 1'b0;
      r_pix <= '0;
    end else if (w_emit) begin
      r_pw  <= 1'b1;
      r_pix <= {1'b0, w_emit_color};
    end else if (pixel_strobe) begin
      r_pw  <= 1'b0;
    end
  end

endmodule

// File: rtl/display_file_decoder.sv
// Display-file fetcher: one 16-bit word at a time, split into bytes
// (upper first) and handed out over a valid/strobe handshake.
module display_file_decoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reload_vsr,
  input  logic [21:0] vsr,
  output logic [21:0] file_address,
  output logic        file_as,
  input  logic [15:0] file_din,
  input  logic        file_bus_ack,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_strobe
);

  logic [21:0] r_addr;
  logic        r_as, r_active;
  logic [15:0] r_buf;
  logic [1:0]  r_cnt;   // bytes left in r_buf: 2 = upper pending, 1 = lower

  assign file_address = r_addr;
  assign file_as      = r_as;
  assign byte_valid   = (r_cnt != 2'd0);
  assign byte_data    = r_cnt[1] ? r_buf[15:8] : r_buf[7:0];

  // fetch control and byte buffer; reload restarts immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_as     <= 1'b0;
      r_active <= 1'b0;
      r_buf    <= '0;
      r_cnt    <= '0;
    end else if (reload_vsr) begin
      r_addr   <= vsr;
      r_cnt    <= '0;
      r_as     <= 1'b1;
      r_active <= 1'b1;
    end else if (r_as && file_bus_ack) begin
      r_buf  <= file_din;
      r_cnt  <= 2'd2;
      r_addr <= r_addr + 22'd2;
      r_as   <= 1'b0;
    end else begin
      if (byte_strobe && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (r_active && !r_as && r_cnt == 2'd0) r_as <= 1'b1;
    end
  end

endmodule

// File: rtl/ica_dca_ctrl.sv
// ICA instruction engine: fetches 32-bit instructions as two 16-bit reads,
// issues register writes, jumps, and the VSR reload to the file decoder.
module ica_dca_ctrl
  import mcd212_pkg::*;
#(
  parameter logic [21:0] ICA_START = 22'h000400
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        field_start,
  output logic [21:0] ica_address,
  output logic        ica_as,
  input  logic [15:0] ica_din,
  input  logic        ica_bus_ack,
  output logic [6:0]  register_adr,
  output logic [23:0] register_data,
  output logic        register_write,
  output logic        reload_vsr,
  output logic [21:0] vsr
);

  ica_state_e  r_state, w_next;
  logic [21:0] r_ptr;
  logic        r_as;
  logic [15:0] r_hi;
  logic [31:0] r_instr;
  ica_instr_t  w_instr;
  logic        w_ack, w_stop;

  assign w_instr = ica_decode(r_instr);
  assign w_ack   = r_as & ica_bus_ack;
  assign w_stop  = (w_instr.op == OP_STOP) || (w_instr.op == OP_DCP_STOP) ||
                   (w_instr.op == OP_VSR_STOP);

  // next state: field_start overrides everything
  always_comb begin
    w_next = r_state;
    if (field_start) w_next = ICA_FETCH_HI;
    else begin
      case (r_state)
        ICA_IDLE:     w_next = ICA_IDLE;
        ICA_FETCH_HI: if (w_ack) w_next = ICA_FETCH_LO;
        ICA_FETCH_LO: if (w_ack) w_next = ICA_EXEC;
        ICA_EXEC:     w_next = w_stop ? ICA_IDLE : ICA_FETCH_HI;
        default:      w_next = ICA_IDLE;
      endcase
    end
  end

  // state register plus pointer / request / instruction capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ICA_IDLE;
      r_ptr   <= '0;
      r_as    <= 1'b0;
      r_hi    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (field_start) begin
        r_as  <= 1'b0;
        r_ptr <= ICA_START;
      end else begin
        // request rises a cycle after entering a fetch state, falls after ack
        if (r_state == ICA_FETCH_HI || r_state == ICA_FETCH_LO) r_as <= ~w_ack;
        else                                                   r_as <= 1'b0;
        if (w_ack && r_state == ICA_FETCH_HI) r_hi <= ica_din;
        if (w_ack && r_state == ICA_FETCH_LO) begin
          r_instr <= {r_hi, ica_din};
          r_ptr   <= r_ptr + 22'd4;
        end
        if (r_state == ICA_EXEC && w_instr.op == OP_JUMP)
          r_ptr <= {w_instr.data[21:1], 1'b0};
      end
    end
  end

  // outputs: register fields are stable between instructions
  always_comb begin
    ica_as         = r_as;
    ica_address    = (r_state == ICA_FETCH_LO) ? r_ptr + 22'd2 : r_ptr;
    register_adr   = w_instr.adr;
    register_data  = w_instr.data;
    register_write = (r_state == ICA_EXEC) && w_instr.op[3];
    reload_vsr     = (r_state == ICA_EXEC) && (w_instr.op == OP_VSR_STOP);
    vsr            = {w_instr.data[21:1], 1'b0};
  end

endmodule

// File: rtl/mcd212_display_path.sv
// MCD212 display-fetch path: ICA engine -> file fetcher -> RL7 decoder.
module mcd212_display_path
  import mcd212_pkg::*;
#(
  parameter logic [21:0] ICA_START  = 22'h000400,
  parameter int          LINE_WIDTH = 384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        field_start,
  output logic [21:0] ica_address,
  output logic        ica_as,
  input  logic [15:0] ica_din,
  input  logic        ica_bus_ack,
  output logic [21:0] file_address,
  output logic        file_as,
  input  logic [15:0] file_din,
  input  logic        file_bus_ack,
  output logic [6:0]  register_adr,
  output logic [23:0] register_data,
  output logic        register_write,
  output logic [7:0]  pixel,
  output logic        pixel_write,
  input  logic        pixel_strobe
);

  logic        w_reload_vsr;
  logic [21:0] w_vsr;
  logic        w_byte_valid, w_byte_strobe;
  logic [7:0]  w_byte_data;

  ica_dca_ctrl #(.ICA_START(ICA_START)) u_ica (
    .clk(clk), .reset_n(reset_n), .field_start(field_start),
    .ica_address(ica_address), .ica_as(ica_as),
    .ica_din(ica_din), .ica_bus_ack(ica_bus_ack),
    .register_adr(register_adr), .register_data(register_data),
    .register_write(register_write),
    .reload_vsr(w_reload_vsr), .vsr(w_vsr)
  );

  display_file_decoder u_file (
    .clk(clk), .reset_n(reset_n),
    .reload_vsr(w_reload_vsr), .vsr(w_vsr),
    .file_address(file_address), .file_as(file_as),
    .file_din(file_din), .file_bus_ack(file_bus_ack),
    .byte_valid(w_byte_valid), .byte_data(w_byte_data),
    .byte_strobe(w_byte_strobe)
  );

  clut_rle #(.LINE_WIDTH(LINE_WIDTH)) u_rle (
    .clk(clk), .reset_n(reset_n), .reload_vsr(w_reload_vsr),
    .byte_valid(w_byte_valid), .byte_data(w_byte_data),
    .byte_strobe(w_byte_strobe),
    .pixel(pixel), .pixel_write(pixel_write), .pixel_strobe(pixel_strobe)
  );

endmodule

// File: tb/tb_mcd212_display_path.sv
// Directed bench for mcd212_display_path with 1-cycle-ack memory models.
module tb_mcd212_display_path;

  logic        clk = 1'b0, reset_n = 1'b0, field_start = 1'b0;
  logic [21:0] ica_address, file_address;
  logic        ica_as, file_as;
  logic [15:0] ica_din = '0, file_din = '0;
  logic        ica_bus_ack = 1'b0, file_bus_ack = 1'b0;
  logic [6:0]  register_adr;
  logic [23:0] register_data;
  logic        register_write;
  logic [7:0]  pixel;
  logic        pixel_write;
  logic        pixel_strobe = 1'b0;

  mcd212_display_path dut (
    .clk(clk), .reset_n(reset_n), .field_start(field_start),
    .ica_address(ica_address), .ica_as(ica_as),
    .ica_din(ica_din), .ica_bus_ack(ica_bus_ack),
    .file_address(file_address), .file_as(file_as),
    .file_din(file_din), .file_bus_ack(file_bus_ack),
    .register_adr(register_adr), .register_data(register_data),
    .register_write(register_write),
    .pixel(pixel), .pixel_write(pixel_write), .pixel_strobe(pixel_strobe)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, prog = 0;
  int ack402_cyc = -100, ack406_cyc = -100, rw_cyc = -100, first_file_cyc = -100;
  int rw_n = 0, file_req_n = 0;
  logic [6:0]  rw_adr = '0;
  logic [23:0] rw_data = '0;
  logic [21:0] first_file_addr = '0;
  logic        ica_as_q = 1'b0, file_as_q = 1'b0;
  logic [21:0] ica_reqs[$];

  function automatic logic [15:0] ica_mem(input int pg, input logic [21:0] a);
    if (pg == 0) begin
      case (a)
        22'h400: return 16'h8A12;
        22'h402: return 16'h3456;
        22'h404: return 16'h5000;
        22'h406: return 16'h1000;
        default: return 16'h0000;
      endcase
    end else begin
      case (a)
        22'h400: return 16'h4000;
        22'h402: return 16'h0800;
        22'h800: return 16'h8B00;
        22'h802: return 16'h00FF;
        default: return 16'h0000;
      endcase
    end
  endfunction

  // bytes: 05 83 03 82 FF 82 79 81 00 85 00 07 00...
  function automatic logic [15:0] file_mem(input logic [21:0] a);
    case (a)
      22'h1000: return 16'h0583;
      22'h1002: return 16'h0382;
      22'h1004: return 16'hFF82;
      22'h1006: return 16'h7981;
      22'h1008: return 16'h0085;
      22'h100A: return 16'h0007;
      default:  return 16'h0000;
    endcase
  endfunction

  // memory models and event monitors
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    ica_bus_ack  <= ica_as && !ica_bus_ack;
    ica_din      <= ica_mem(prog, ica_address);
    file_bus_ack <= file_as && !file_bus_ack;
    file_din     <= file_mem(file_address);
    ica_as_q     <= ica_as;
    file_as_q    <= file_as;
    if (ica_as && !ica_as_q) ica_reqs.push_back(ica_address);
    if (ica_as && ica_bus_ack && ica_address == 22'h402) ack402_cyc <= cyc;
    if (ica_as && ica_bus_ack && ica_address == 22'h406) ack406_cyc <= cyc;
    if (register_write) begin
      rw_n    <= rw_n + 1;
      rw_adr  <= register_adr;
      rw_data <= register_data;
      rw_cyc  <= cyc;
    end
    if (file_as && !file_as_q) begin
      file_req_n <= file_req_n + 1;
      if (file_req_n == 0) begin
        first_file_addr <= file_address;
        first_file_cyc  <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_pix(output logic [7:0] p);
    int n;
    n = 0;
    p = '0;
    while (!pixel_write && n < 40) begin @(negedge clk); n++; end
    if (!pixel_write) check("pix_timeout", 32'(pixel_write), 32'd1);
    else begin
      p = pixel;
      pixel_strobe = 1'b1;
      @(negedge clk);
      pixel_strobe = 1'b0;
    end
  endtask

  task automatic pulse_field_start();
    field_start = 1'b1;
    @(negedge clk);
    field_start = 1'b0;
  endtask

  initial begin
    logic [7:0] p, pv;
    int good, bad, fr, nq, rw0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ica_as",     32'(ica_as),         32'd0);
    check("rst_ica_addr",   32'(ica_address),    32'd0);
    check("rst_file_as",    32'(file_as),        32'd0);
    check("rst_file_addr",  32'(file_address),   32'd0);
    check("rst_reg_write",  32'(register_write), 32'd0);
    check("rst_reg_adr",    32'(register_adr),   32'd0);
    check("rst_reg_data",   32'(register_data),  32'd0);
    check("rst_pix_write",  32'(pixel_write),    32'd0);
    check("rst_pix",        32'(pixel),          32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_ica_req", 32'(ica_reqs.size()), 32'd0);
    check("idle_no_file_req", 32'(file_req_n), 32'd0);

    // field start: register write then VSR reload to 0x1000
    prog = 0;
    pulse_field_start();
    for (int i = 0; i < 60 && file_req_n == 0; i++) @(negedge clk);
    check("rw_count",      32'(rw_n),            32'd1);
    check("rw_adr",        32'(rw_adr),          32'h0A);
    check("rw_data",       32'(rw_data),         32'h123456);
    check("rw_latency",    32'(rw_cyc),          32'(ack402_cyc + 1));
    check("file_addr0",    32'(first_file_addr), 32'h1000);
    check("file_latency",  32'(first_file_cyc),  32'(ack406_cyc + 2));
    nq = ica_reqs.size();
    repeat (20) @(negedge clk);
    check("ica_req_count", 32'(nq), 32'd4);
    check("ica_stopped",   32'(ica_reqs.size() - nq), 32'd0);

    // 05 / 83 03
    get_pix(p); check("pix_lit05", 32'(p), 32'h05);
    for (int i = 0; i < 3; i++) begin
      get_pix(p); check("pix_run03", 32'(p), 32'h03);
    end

    // 82 FF: take 10, then withhold the strobe mid-run
    good = 0;
    for (int i = 0; i < 10; i++) begin get_pix(p); if (p == 8'h02) good++; end
    pv = pixel;
    fr = file_req_n;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!pixel_write || pixel !== pv) bad++;
    end
    check("stall_pix",      32'(pv),              32'h02);
    check("stall_hold",     32'(bad),             32'd0);
    check("stall_no_fetch", 32'(file_req_n - fr), 32'd0);

    // rest of the 255 run plus 82 79 (121) -> x = 380
    for (int i = 0; i < 366; i++) begin get_pix(p); if (p == 8'h02) good++; end
    check("run02_count", 32'(good), 32'd376);

    // 81 00 at x=380: clipped to 4 pixels
    for (int i = 0; i < 4; i++) begin
      get_pix(p); check("eol_run01", 32'(p), 32'h01);
    end

    // 85 00 at x=0 must give a full line, then literal 07
    good = 0;
    for (int i = 0; i < 384; i++) begin get_pix(p); if (p == 8'h05) good++; end
    check("wrap_full_line", 32'(good), 32'd384);
    get_pix(p); check("after_wrap", 32'(p), 32'h07);

    // JUMP program: 0x400 -> 0x800, register write, STOP
    nq  = ica_reqs.size();
    rw0 = rw_n;
    prog = 1;
    pulse_field_start();
    for (int i = 0; i < 80 && rw_n == rw0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("jump_req_count", 32'(ica_reqs.size() - nq), 32'd6);
    check("jump_first",     32'(ica_reqs[nq]),         32'h400);
    check("jump_target",    32'(ica_reqs[nq + 2]),     32'h800);
    check("jump_next",      32'(ica_reqs[nq + 4]),     32'h804);
    check("jump_rw_adr",    32'(rw_adr),               32'h0B);
    check("jump_rw_data",   32'(rw_data),              32'h0000FF);
    nq = ica_reqs.size();
    repeat (20) @(negedge clk);
    check("stop_halts",     32'(ica_reqs.size() - nq), 32'd0);

    // asynchronous reset in the middle of an ICA fetch
    prog = 0;
    pulse_field_start();
    for (int i = 0; i < 10 && !ica_as; i++) @(negedge clk);
    check("midfetch_as", 32'(ica_as), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ica_as",    32'(ica_as),         32'd0);
    check("arst_ica_addr",  32'(ica_address),    32'd0);
    check("arst_file_as",   32'(file_as),        32'd0);
    check("arst_file_addr", 32'(file_address),   32'd0);
    check("arst_reg_write", 32'(register_write), 32'd0);
    check("arst_reg_adr",   32'(register_adr),   32'd0);
    check("arst_reg_data",  32'(register_data),  32'd0);
    check("arst_pix_write", 32'(pixel_write),    32'd0);
    check("arst_pix",       32'(pixel),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
